keypad_scan_debounce: RTL and testbench

Upstream stage of the keypad display path. It drives the 4x4 keypad rows one at a time and watches the column lines. When one key is pressed it locks onto that key, debounces both press and release, and emits a one-cycle key event with a 4-bit hex code. The event feeds the two-digit history register that drives the seven-segment multiplexer. Runs entirely on the divided system clock `clk`.

---
 rtl/keypad_scan_debounce.sv | 115 +++++++++++
 tb/tb_keypad_scan_debounce.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 keypad row scanner with press/release debounce and one-cycle key events.
// Define KEYPAD_REPEAT_EN to add auto-repeat of the held key (REPEAT_DELAY, REPEAT_RATE).
module keypad_scan_debounce #(
  parameter int SCAN_DIV = 4,
  parameter int DB_CYCLES = 8,
  parameter int CNT_W = 8
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  // Nibble {row, col} holds the hex code of that key; col 0 is the leftmost column.
  localparam logic [63:0] KEY_MAP = 64'hdf0e_c987_b654_a321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t state;
  logic [3:0] sync1, col_s, low;
  logic [1:0] row, cand_col, low_col;
  logic [CNT_W-1:0] cnt;
  logic single, cand_low, dwell_end, db_end;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep;
  logic rep_fire;
  assign rep_fire = rep == RW'(REPEAT_DELAY - 1);
`endif
  always_comb begin
    low = ~col_s;
    single = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    low_col = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    cand_low = ~col_s[cand_col];
    dwell_end = cnt == CNT_W'(SCAN_DIV - 1);
    db_end = cnt == CNT_W'(DB_CYCLES - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 4'hf;
      col_s <= 4'hf;
      state <= SCAN;
      row <= 2'd0;
      rows <= 4'b1110;
      cnt <= '0;
      cand_col <= 2'd0;
      key_code <= 4'h0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep <= '0;
`endif
    end else begin
      sync1 <= columns;
      col_s <= sync1;
      key_valid <= 1'b0;
      case (state)
        SCAN:
          if (!dwell_end) cnt <= cnt + 1'b1;
          else if (single) begin
            state <= DEBOUNCE;
            cand_col <= low_col;
            cnt <= '0;
          end else begin
            row <= row + 1'b1;
            rows <= {rows[2:0], rows[3]};
            cnt <= '0;
          end
        DEBOUNCE:
          if (!cand_low) begin
            state <= SCAN;
            row <= row + 1'b1;
            rows <= {rows[2:0], rows[3]};
            cnt <= '0;
          end else if (db_end) begin
            state <= HELD;
            key_code <= KEY_MAP[{row, cand_col, 2'b00} +: 4];
            key_valid <= 1'b1;
            key_held <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep <= '0;
`endif
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!cand_low) begin
            state <= RELEASE;
            cnt <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_fire) begin
            key_valid <= 1'b1;
            rep <= RW'(REPEAT_DELAY - REPEAT_RATE);
          end else rep <= rep + 1'b1;
`endif
        RELEASE:
          if (cand_low) state <= HELD;
          else if (db_end) begin
            state <= SCAN;
            row <= row + 1'b1;
            rows <= {rows[2:0], rows[3]};
            cnt <= '0;
            key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep <= '0;
`endif
          end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: randomized keypad stimulus checked each cycle against a timeline model
// that tracks scan/debounce progress as elapsed edge counts over a history of column values.
module tb_keypad_scan_debounce;
  localparam int SD = 4, DB = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int RD = 64, RR = 16;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] columns, rows, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  int nvec = 0, nerr = 0, ed = 0;
  int m_mode, m_row, m_start, m_mark, m_c, ht;
  logic [3:0] m_rows, m_code;
  logic m_valid, m_held;
  logic [3:0] colhist [4];
  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_debounce #(.SCAN_DIV(SD), .DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .columns(columns), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held));

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    columns = 4'hf;
    for (int i = 0; i < 16; i++) if (keys[i] && !rows[i / 4]) columns[i % 4] = 1'b0;
  end

  function automatic logic [3:0] pad(input logic [15:0] k, input int r);
    logic [3:0] c;
    c = 4'hf;
    for (int i = 0; i < 4; i++) if (k[r * 4 + i]) c[i] = 1'b0;
    return c;
  endfunction

  task automatic model_init();
    ed = 0; m_mode = 0; m_row = 0; m_start = 0; m_mark = 0; m_c = 0; ht = 0;
    m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_rows = 4'b1110;
  endtask

  // Decision at edge e sees columns as they were three edges earlier (two sync stages + register).
  task automatic model_step(input int e);
    logic [3:0] s;
    s = (e >= 3) ? colhist[(e - 3) % 4] : 4'hf;
    m_valid = 1'b0;
    case (m_mode)
      0: if (e - m_start == SD) begin
           if ($countones(~s) == 1) begin
             m_mode = 1; m_mark = e;
             for (int c = 0; c < 4; c++) if (!s[c]) m_c = c;
           end else begin
             m_row = (m_row + 1) % 4; m_start = e;
           end
         end
      1: if (s[m_c]) begin
           m_mode = 0; m_row = (m_row + 1) % 4; m_start = e;
         end else if (e - m_mark == DB) begin
           m_mode = 2; m_valid = 1'b1; m_code = key_map[m_row * 4 + m_c]; m_held = 1'b1; ht = 0;
         end
      2: if (s[m_c]) begin
           m_mode = 3; m_mark = e;
         end else begin
           ht++;
`ifdef KEYPAD_REPEAT_EN
           if (ht >= RD && (ht - RD) % RR == 0) m_valid = 1'b1;
`endif
         end
      3: if (!s[m_c]) m_mode = 2;
         else if (e - m_mark == DB) begin
           m_mode = 0; m_row = (m_row + 1) % 4; m_start = e; m_held = 1'b0;
         end
      default: ;
    endcase
    m_rows = 4'b1111;
    m_rows[m_row] = 1'b0;
  endtask

  task automatic tick();
    colhist[ed % 4] = pad(keys, m_row);
    @(posedge clk);
    ed++;
    model_step(ed);
    @(negedge clk);
  endtask

  task automatic do_reset();
    keys = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    logic [3:0] want;
    do_reset();
    nvec++;
    if ({rows, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_values: got rows=%b code=%h valid=%b held=%b want 1110/0/0/0", rows, key_code, key_valid, key_held);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      want = 4'b1111;
      want[(ed / SD) % 4] = 1'b0;
      nvec++;
      if (rows !== want || key_valid !== 1'b0) begin
        nerr++;
        $display("FAIL idle_scan cyc %0d: got rows=%b valid=%b want rows=%b valid=0", ed, rows, key_valid, want);
      end
    end
  endtask

  task automatic test_clean_press();
    int k, idle;
    logic [3:0] got [$];
    for (int n = 0; n < 6; n++) begin
      k = (n == 0) ? 6 : int'($urandom_range(15));
      idle = $urandom_range(15);
      got = {};
      for (int i = 0; i < 100; i++) begin
        keys = (i >= idle && i < idle + 50) ? 16'h1 << k : '0;
        tick();
        nvec++;
        if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
          nerr++;
          $display("FAIL clean_press cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
        end
        if (key_valid === 1'b1) got.push_back(key_code);
      end
      nvec++;
      if (got.size() != 1 || got[0] !== key_map[k]) begin
        nerr++;
        $display("FAIL clean_press_events key %0d: got %0d events (first %h) want 1 event code %h", k, got.size(), got.size() ? got[0] : 4'hx, key_map[k]);
      end
    end
  endtask

  task automatic test_bounce();
    int ph;
    logic [3:0] got [$];
    ph = $urandom_range(2);
    for (int i = 0; i < 110; i++) begin
      keys = (i < 30) ? ((((i + ph) / 3) % 2 == 0) ? 16'h1 << 13 : '0) : (i < 80) ? 16'h1 << 13 : '0;
      tick();
      nvec++;
      if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
        nerr++;
        $display("FAIL bounce cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
      end
      if (key_valid === 1'b1) got.push_back(key_code);
    end
    nvec++;
    if (got.size() != 1 || got[0] !== 4'h0) begin
      nerr++;
      $display("FAIL bounce_events: got %0d events (first %h) want 1 event code 0", got.size(), got.size() ? got[0] : 4'hx);
    end
  endtask

  task automatic test_second_key();
    logic [15:0] a, f;
    logic [3:0] got [$];
    a = 16'h1 << 3;
    f = 16'h1 << 5;
    for (int i = 0; i < 150; i++) begin
      keys = (i < 40) ? a : (i < 50) ? (a | f) : (i < 54) ? ((i % 2) ? (a | f) : f) : (i < 120) ? f : '0;
      tick();
      nvec++;
      if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
        nerr++;
        $display("FAIL second_key cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
      end
      if (key_valid === 1'b1) got.push_back(key_code);
    end
    nvec++;
    if (got.size() != 2 || got[0] !== 4'hA || got[1] !== 4'h5) begin
      nerr++;
      $display("FAIL second_key_events: got %0d events (%h,%h) want 2 events (a,5)", got.size(), got.size() > 0 ? got[0] : 4'hx, got.size() > 1 ? got[1] : 4'hx);
    end
  endtask

  task automatic test_multi_low();
    int r, c1, c2, nev;
    for (int n = 0; n < 3; n++) begin
      r = (n == 0) ? 0 : int'($urandom_range(3));
      c1 = (n == 0) ? 0 : int'($urandom_range(3));
      c2 = (n == 0) ? 1 : (c1 + 1 + int'($urandom_range(2))) % 4;
      nev = 0;
      for (int i = 0; i < 56; i++) begin
        keys = (i < 48) ? (16'h1 << (r * 4 + c1)) | (16'h1 << (r * 4 + c2)) : '0;
        tick();
        nvec++;
        if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
          nerr++;
          $display("FAIL multi_low cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
        end
        if (key_valid === 1'b1) nev++;
      end
      nvec++;
      if (nev != 0) begin
        nerr++;
        $display("FAIL multi_low_events row %0d cols %0d,%0d: got %0d events want 0", r, c1, c2, nev);
      end
    end
  endtask

  task automatic test_async_reset();
    int k, nev;
    logic hit;
    for (int n = 0; n < 2; n++) begin
      k = $urandom_range(15);
      keys = 16'h1 << k;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        tick();
        nvec++;
        if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
          nerr++;
          $display("FAIL async_reset_pre cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
        end
        hit = (n == 0) ? (m_mode == 1 && ed - m_mark == 3) : (m_mode == 2 && ht >= 10);
      end
      nvec++;
      if (!hit) begin
        nerr++;
        $display("FAIL async_reset_reach phase %0d: got no lock within 200 cycles want lock", n);
      end
      #2 reset = 1'b1;
      keys = '0;
      #1;
      nvec++;
      if ({rows, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
        nerr++;
        $display("FAIL async_reset phase %0d: got rows=%b code=%h valid=%b held=%b want 1110/0/0/0", n, rows, key_code, key_valid, key_held);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_init();
      nev = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        nvec++;
        if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
          nerr++;
          $display("FAIL async_reset_post cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
        end
        if (key_valid === 1'b1) nev++;
      end
      nvec++;
      if (nev != 0) begin
        nerr++;
        $display("FAIL async_reset_events phase %0d: got %0d events want 0", n, nev);
      end
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int first;
    int offs [$];
    int want [4] = '{0, 64, 80, 96};
    first = -1;
    keys = 16'h1 << 10;
    for (int i = 0; i < 200 && (first < 0 || ed - first < 100); i++) begin
      tick();
      nvec++;
      if ({rows, key_code, key_valid, key_held} !== {m_rows, m_code, m_valid, m_held}) begin
        nerr++;
        $display("FAIL repeat cyc %0d: rows/code/valid/held got %b/%h/%b/%b want %b/%h/%b/%b", ed, rows, key_code, key_valid, key_held, m_rows, m_code, m_valid, m_held);
      end
      if (key_valid === 1'b1) begin
        if (first < 0) first = ed;
        offs.push_back(ed - first);
      end
    end
    keys = '0;
    repeat (30) tick();
    nvec++;
    if (offs.size() != 4 || offs[0] != want[0] || offs[1] != want[1] || offs[2] != want[2] || offs[3] != want[3]) begin
      nerr++;
      $display("FAIL repeat_offsets: got %0d pulses (%p) want 0,64,80,96", offs.size(), offs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_second_key();
    test_multi_low();
    test_async_reset();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
